// File: rtl/scrambler_tx_sequencer_if.sv
// Upstream block bus: one 66-bit block (sync header + payload) per valid/ready transfer.
interface scrambler_tx_sequencer_if #(
  parameter int unsigned HDR_W     = 2,
  parameter int unsigned PAYLOAD_W = 64
);
  logic                 blk_valid;
  logic                 blk_ready;
  logic [HDR_W-1:0]     blk_header;
  logic [PAYLOAD_W-1:0] blk_payload;

  modport master (
    output blk_valid,
    output blk_header,
    output blk_payload,
    input  blk_ready
  );

  modport slave (
    input  blk_valid,
    input  blk_header,
    input  blk_payload,
    output blk_ready
  );
endinterface

// File: rtl/scrambler_tx_sequencer.sv
// 64b/66b transmit sequencer: serializes header bits in the clear and payload bits
// through an external x^58+x^39+1 scrambler, owning its clear and enable.
module scrambler_tx_sequencer #(
  parameter int unsigned PAYLOAD_W = 64,
  parameter int unsigned HDR_W     = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                    CLK,
  input  logic                    reset,
  scrambler_tx_sequencer_if.slave blk,
  input  logic                    reinit,
  output logic                    scr_reset,
  output logic                    scr_enable,
  output logic                    scr_bit_in,
  input  logic                    scr_bit_out,
  output logic                    ser_bit,
  output logic                    ser_valid,
  output logic                    hdr_err,
  output logic [CNT_W-1:0]        blk_count
);

  localparam int unsigned MAX_W     = (PAYLOAD_W > HDR_W) ? PAYLOAD_W : HDR_W;
  localparam int unsigned BIT_CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [BIT_CNT_W-1:0] HDR_LAST = BIT_CNT_W'(HDR_W - 1);
  localparam logic [BIT_CNT_W-1:0] PAY_LAST = BIT_CNT_W'(PAYLOAD_W - 1);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    HDR  = 2'd2,
    PAY  = 2'd3
  } state_t;

  state_t               state;
  logic [BIT_CNT_W-1:0] cnt;
  logic [HDR_W-1:0]     hdr_sr;
  logic [PAYLOAD_W-1:0] pay_sr;
  logic                 reinit_pend;

  logic ready;
  logic xfer;
  logic last_hdr;
  logic last_pay;
  logic bad_hdr;

  assign last_hdr = (state == HDR) && (cnt == HDR_LAST);
  assign last_pay = (state == PAY) && (cnt == PAY_LAST);
  assign bad_hdr  = (blk.blk_header == '0) || (blk.blk_header == '1);
  assign xfer     = blk.blk_valid && ready;

  // Acceptance window: idle, or the last payload bit so blocks chain without a bubble.
  always_comb begin
    ready = 1'b0;
    case (state)
      IDLE:    ready = !reinit_pend;
      PAY:     ready = last_pay && !reinit_pend && !reinit;
      default: ready = 1'b0;
    endcase
  end

  assign blk.blk_ready = ready;

  // Gated by reset so the clear stays low while held in reset, though state reads INIT.
  assign scr_reset  = (state == INIT) && reset;
  assign scr_enable = (state == PAY);
  assign scr_bit_in = (state == PAY) ? pay_sr[0] : 1'b0;
  assign ser_valid  = (state == HDR) || (state == PAY);

  // Payload bits return through the scrambler in the same cycle.
  always_comb begin
    ser_bit = 1'b0;
    case (state)
      HDR:     ser_bit = hdr_sr[0];
      PAY:     ser_bit = scr_bit_out;
      default: ser_bit = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state       <= INIT;
      cnt         <= '0;
      hdr_sr      <= '0;
      pay_sr      <= '0;
      reinit_pend <= 1'b0;
      hdr_err     <= 1'b0;
      blk_count   <= '0;
    end else begin
      hdr_err <= xfer && bad_hdr;

      if (xfer) begin
        hdr_sr <= blk.blk_header;
        pay_sr <= blk.blk_payload;
      end else if (state == HDR) begin
        hdr_sr <= hdr_sr >> 1;
      end else if (state == PAY) begin
        pay_sr <= pay_sr >> 1;
      end

      if (reinit) begin
        reinit_pend <= 1'b1;
      end

      case (state)
        INIT: begin
          state       <= IDLE;
          reinit_pend <= reinit;
        end
        IDLE: begin
          if (reinit_pend) begin
            state <= INIT;
          end else if (xfer) begin
            state <= HDR;
            cnt   <= '0;
          end
        end
        HDR: begin
          if (last_hdr) begin
            state <= PAY;
            cnt   <= '0;
          end else begin
            cnt <= cnt + BIT_CNT_W'(1);
          end
        end
        PAY: begin
          if (last_pay) begin
            blk_count <= blk_count + CNT_W'(1);
            cnt       <= '0;
            if (xfer) begin
              state <= HDR;
            end else if (reinit_pend || reinit) begin
              state <= INIT;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + BIT_CNT_W'(1);
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_scrambler_tx_sequencer.sv
// Scoreboard bench for scrambler_tx_sequencer with an attached x^58+x^39+1 scrambler.
module tb_scrambler_tx_sequencer;

  localparam int unsigned PAYLOAD_W = 64;
  localparam int unsigned HDR_W     = 2;
  localparam int unsigned CNT_W     = 16;

  logic             CLK = 1'b0;
  logic             reset = 1'b0;
  logic             reinit;
  logic             scr_reset, scr_enable, scr_bit_in, scr_bit_out;
  logic             ser_bit, ser_valid, hdr_err;
  logic [CNT_W-1:0] blk_count;

  always #5 CLK = ~CLK;

  scrambler_tx_sequencer_if #(.HDR_W(HDR_W), .PAYLOAD_W(PAYLOAD_W)) blk_if ();

  scrambler_tx_sequencer #(.PAYLOAD_W(PAYLOAD_W), .HDR_W(HDR_W), .CNT_W(CNT_W)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .blk         (blk_if),
    .reinit      (reinit),
    .scr_reset   (scr_reset),
    .scr_enable  (scr_enable),
    .scr_bit_in  (scr_bit_in),
    .scr_bit_out (scr_bit_out),
    .ser_bit     (ser_bit),
    .ser_valid   (ser_valid),
    .hdr_err     (hdr_err),
    .blk_count   (blk_count)
  );

  // Attached scrambler; starts with garbage so a missing clear is visible.
  logic [57:0] scr_s = '1;
  assign scr_bit_out = scr_bit_in ^ scr_s[38] ^ scr_s[57];
  always @(posedge CLK) begin
    if (scr_reset)       scr_s <= '0;
    else if (scr_enable) scr_s <= {scr_s[56:0], scr_bit_out};
  end

  typedef struct packed {logic b; logic pay; logic pin; logic last;} exp_t;
  exp_t        exp_q[$];
  bit          hist[$];
  bit          ser_log[$];
  bit          clr_pend = 1'b0;
  int unsigned done_blks = 0;
  int          n_chk = 0, n_fail = 0;
  int          en_cyc = 0, scr_reset_cyc = 0, rdy_last = 0, hdr_pulses = 0;
  logic        exp_hdr_err = 1'b0;
  bit          chk_cnt = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: header sent raw; payload out[k] = in[k] ^ out[k-39] ^ out[k-58] since last clear.
  function automatic void model_block(input logic [HDR_W-1:0] h, input logic [PAYLOAD_W-1:0] p);
    logic o, t39, t58;
    int   n;
    if (clr_pend) begin
      hist.delete();
      clr_pend = 1'b0;
    end
    for (int i = 0; i < HDR_W; i++) exp_q.push_back('{b: h[i], pay: 1'b0, pin: 1'b0, last: 1'b0});
    for (int i = 0; i < PAYLOAD_W; i++) begin
      n   = hist.size();
      t39 = (n >= 39) ? hist[n-39] : 1'b0;
      t58 = (n >= 58) ? hist[n-58] : 1'b0;
      o   = p[i] ^ t39 ^ t58;
      hist.push_back(o);
      if (hist.size() > 58) void'(hist.pop_front());
      exp_q.push_back('{b: o, pay: 1'b1, pin: p[i], last: (i == PAYLOAD_W - 1)});
    end
  endfunction

  // Monitor: pops the scoreboard whenever the serial line is valid.
  always @(negedge CLK) begin
    exp_t e;
    if (!reset) begin
      exp_hdr_err = 1'b0;
      chk_cnt     = 1'b0;
    end else begin
      chk("hdr_err", hdr_err, exp_hdr_err);
      if (hdr_err) hdr_pulses++;
      if (chk_cnt) chk("blk_count", blk_count, CNT_W'(done_blks));
      chk_cnt = 1'b0;
      if (scr_reset) scr_reset_cyc++;
      if (scr_enable) en_cyc++;
      chk("scr_reset_with_enable", scr_reset & scr_enable, 0);
      if (ser_valid) begin
        ser_log.push_back(ser_bit);
        if (exp_q.size() == 0) begin
          chk("ser_valid_without_block", ser_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("ser_bit", ser_bit, e.b);
          chk("scr_enable", scr_enable, e.pay);
          if (e.pay) chk("scr_bit_in", scr_bit_in, e.pin);
          if (e.last) begin
            done_blks++;
            chk_cnt = 1'b1;
            if (blk_if.blk_ready) rdy_last++;
          end
        end
      end else begin
        chk("scr_enable_outside_block", scr_enable, 0);
      end
      exp_hdr_err = blk_if.blk_valid && blk_if.blk_ready &&
                    (blk_if.blk_header == 2'b00 || blk_if.blk_header == 2'b11);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_block(input logic [HDR_W-1:0] h, input logic [PAYLOAD_W-1:0] p);
    bit got = 1'b0;
    blk_if.blk_valid   = 1'b1;
    blk_if.blk_header  = h;
    blk_if.blk_payload = p;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge CLK);
      if (blk_if.blk_ready) begin
        got = 1'b1;
        model_block(h, p);
      end
    end
    if (!got) chk("handshake_timeout", blk_if.blk_ready, 1);
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_idle();
    blk_if.blk_valid   = 1'b0;
    blk_if.blk_header  = 2'($urandom);
    blk_if.blk_payload = {$urandom, $urandom};
  endtask

  task automatic pulse_reinit();
    reinit   = 1'b1;
    clr_pend = 1'b1;
    cycles(1);
    reinit = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 600 && exp_q.size() != 0; t++) @(posedge CLK);
    #1;
    chk("drain_pending_bits", exp_q.size(), 0);
    cycles(2);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_blk_ready"}, blk_if.blk_ready, 0);
    chk({tag, "_scr_reset"}, scr_reset, 0);
    chk({tag, "_scr_enable"}, scr_enable, 0);
    chk({tag, "_scr_bit_in"}, scr_bit_in, 0);
    chk({tag, "_ser_bit"}, ser_bit, 0);
    chk({tag, "_ser_valid"}, ser_valid, 0);
    chk({tag, "_hdr_err"}, hdr_err, 0);
    chk({tag, "_blk_count"}, blk_count, 0);
  endtask

  task automatic watch_b2b();
    bit sv[200];
    bit rd[200];
    bit seen = 1'b0;
    int nv = 0, nr = 0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(negedge CLK);
      if (ser_valid) seen = 1'b1;
    end
    chk("b2b_start", ser_valid, 1);
    sv[0] = ser_valid;
    rd[0] = blk_if.blk_ready;
    for (int c = 1; c < 200; c++) begin
      @(negedge CLK);
      sv[c] = ser_valid;
      rd[c] = blk_if.blk_ready;
    end
    for (int c = 0; c < 198; c++) nv += int'(sv[c]);
    for (int c = 0; c < 197; c++) nr += int'(rd[c]);
    chk("b2b_ser_valid_run", nv, 198);
    chk("b2b_ser_valid_after", sv[198], 0);
    chk("b2b_ready_65", rd[65], 1);
    chk("b2b_ready_131", rd[131], 1);
    chk("b2b_ready_count", nr, 2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 2000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, base2, orv;
    reinit = 1'b0;
    bus_idle();

    // Reset held, then released away from the clock edge.
    repeat (3) @(posedge CLK);
    #1;
    check_zero("in_reset");
    reset = 1'b1;
    #1;
    chk("init_scr_reset", scr_reset, 1);
    chk("init_blk_ready", blk_if.blk_ready, 0);
    @(posedge CLK);
    #1;
    chk("idle_scr_reset", scr_reset, 0);
    chk("idle_blk_ready", blk_if.blk_ready, 1);
    chk("idle_ser_valid", ser_valid, 0);
    chk("idle_blk_count", blk_count, 0);

    // Single zero-payload block after a fresh clear.
    ser_log.delete();
    base = en_cyc;
    send_block(2'b01, 64'h0);
    bus_idle();
    drain();
    chk("single_len", ser_log.size(), 66);
    chk("single_hdr0", ser_log[0], 1);
    chk("single_hdr1", ser_log[1], 0);
    orv = 0;
    for (int i = 2; i < 66; i++) orv |= int'(ser_log[i]);
    chk("single_payload_zero", orv, 0);
    chk("single_enable_cycles", en_cyc - base, 64);
    chk("single_blk_count", blk_count, 1);

    // Three back-to-back blocks.
    fork
      watch_b2b();
      begin
        for (int k = 0; k < 3; k++) send_block((k % 2 == 0) ? 2'b01 : 2'b10, {$urandom, $urandom});
        bus_idle();
      end
    join
    drain();
    chk("b2b_blk_count", blk_count, 4);

    // Single-bit payload after a reinit clear: known scrambler impulse response.
    pulse_reinit();
    ser_log.delete();
    send_block(2'b10, 64'h1);
    bus_idle();
    drain();
    chk("impulse_hdr0", ser_log[0], 0);
    chk("impulse_hdr1", ser_log[1], 1);
    chk("impulse_bit0", ser_log[2], 1);
    orv = 0;
    for (int i = 3; i <= 40; i++) orv |= int'(ser_log[i]);
    chk("impulse_bits1_38", orv, 0);
    chk("impulse_bit39", ser_log[41], 1);

    // Invalid header still transmitted, valid one raises no flag.
    ser_log.delete();
    base = hdr_pulses;
    send_block(2'b11, {$urandom, $urandom});
    send_block(2'b10, {$urandom, $urandom});
    bus_idle();
    drain();
    chk("hdr_err_pulses", hdr_pulses - base, 1);
    chk("hdr_err_len", ser_log.size(), 132);

    // reinit at payload bit 10 with the next block already waiting.
    base  = rdy_last;
    base2 = scr_reset_cyc;
    send_block(2'b01, {$urandom, $urandom});
    blk_if.blk_header  = 2'b10;
    blk_if.blk_payload = {$urandom, $urandom};
    cycles(12);
    pulse_reinit();
    send_block(blk_if.blk_header, blk_if.blk_payload);
    chk("reinit_ready_at_boundary", rdy_last - base, 0);
    chk("reinit_init_before_next", scr_reset_cyc - base2, 1);
    bus_idle();
    drain();

    // Reset in the middle of payload bit 30.
    send_block(2'b10, {$urandom, $urandom});
    cycles(32);
    reset = 1'b0;
    #1;
    check_zero("mid_reset");
    exp_q.delete();
    hist.delete();
    clr_pend  = 1'b0;
    done_blks = 0;
    blk_if.blk_valid   = 1'b1;
    blk_if.blk_header  = 2'b01;
    blk_if.blk_payload = {$urandom, $urandom};
    @(posedge CLK);
    #1;
    base2 = scr_reset_cyc;
    reset = 1'b1;
    #1;
    chk("post_reset_scr_reset", scr_reset, 1);
    chk("post_reset_blk_ready", blk_if.blk_ready, 0);
    send_block(blk_if.blk_header, blk_if.blk_payload);
    chk("post_reset_init_first", scr_reset_cyc - base2, 1);
    bus_idle();
    drain();
    chk("post_reset_blk_count", blk_count, 1);

    // Randomized traffic with gaps and reinit pulses between blocks.
    for (int k = 0; k < 30; k++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      if (gap > 0) begin
        bus_idle();
        if ($urandom_range(0, 3) == 0) pulse_reinit();
        cycles(gap);
      end
      send_block(2'($urandom), {$urandom, $urandom});
    end
    bus_idle();
    drain();
    chk("final_blk_count", blk_count, CNT_W'(done_blks));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
